conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Upstream feeder for the first convolution layer: takes the raster-order 8-bit pixel stream (in_valid/in_data, one pixel per strobe) and emits each complete K x K window for valid, unpadded convolution.
- Holds the previous K-1 image rows in line buffers and a K x K shift-register window.
- Tags each window with its top-left coordinate and flags end of frame, so the downstream MAC stage carries no addressing logic.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- DATA_W, 8, pixel width in bits
- K, 3, window size (K x K)
- CW, $clog2(IMG_W), width of column counter and win_col
- RW, $clog2(IMG_H), width of row counter and win_row

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  pixel strobe; one pixel accepted per cycle it is high
- in_data  in  DATA_W  pixel value, raster order
- win_valid  out  1  one-cycle pulse: win_data/win_row/win_col valid
- win_data  out  K*K*DATA_W  window; element (r,c) at bits [DATA_W*(K*r+c) +: DATA_W] = pixel(win_row+r, win_col+c)
- win_row  out  RW  window top-left row, 0..IMG_H-K
- win_col  out  CW  window top-left column, 0..IMG_W-K
- frame_done  out  1  one-cycle pulse with the last window of a frame

Behaviour:
- Reset (async, rst=1): col_cnt=0, row_cnt=0, window regs=0, and all outputs 0 (win_valid, win_data, win_row, win_col, frame_done).
  - Line-buffer contents are not cleared; stale rows are never emitted because of the row gating below.
- No backpressure: in_valid may be high every cycle or sparsely pulsed (e.g. 1 in 51). Idle cycles hold all state; outputs hold their last values with win_valid=0.
- On each accepted pixel at (y=row_cnt, x=col_cnt):
  - Read lb_top[x] (pixel y-2,x) and lb_mid[x] (pixel y-1,x).
  - Shift the window left one column. Insert new right column {lb_top[x], lb_mid[x], in_data} as rows 0..K-1.
  - Write lb_top[x] <= lb_mid[x] and lb_mid[x] <= in_data. Read-before-write at the same address in the same cycle.
  - Generalises to K-1 chained line buffers.
- Window emission: if y >= K-1 and x >= K-1, then on the next edge (latency 1 cycle from the accepting edge) drive win_valid=1, win_data=window, win_row=y-(K-1), win_col=x-(K-1).
  - Columns 0..K-2 of each row only refill the window. No window ever straddles a row boundary.
- Counter wrap:
  - col_cnt increments and wraps IMG_W-1 -> 0 with row_cnt++.
  - At (IMG_H-1, IMG_W-1) both counters return to 0 and frame_done pulses in the same cycle as that window's win_valid.
  - The next accepted pixel starts a new frame with no gap required. Trailing flush pixels are therefore treated as a new frame.
- Windows per frame: exactly (IMG_H-K+1)*(IMG_W-K+1) = 676 with defaults.
- Reset mid-frame: the frame is discarded, counting restarts at (0,0), and no window containing pre-reset data may appear.
- Arithmetic: counters unsigned, no saturation. Pixel data is passed through unmodified; no sign extension.

Decomposition:
- Shared package cnn_pkg: IMG_W, IMG_H, DATA_W, K constants. Helper function win_idx(r,c) = K*r+c, also used by downstream conv layers to unpack win_data.
- Sub-module line_buffer: IMG_W x DATA_W memory with read-before-write at a single address, instantiated K-1 times and chained.
- Counters, window shift register and output registers stay in conv_window_gen.

Test Plan:
- Ramp pattern, pixel(y,x) = (y*28+x) mod 256, one pixel per 51 cycles -> first win_valid exactly 1 cycle after pixel 58 is accepted; row=0, col=0; elements 0,1,2,28,29,30,56,57,58.
- Same frame, count outputs -> exactly 676 win_valid pulses. Last has row=25, col=25, elements 213,214,215,241,242,243,13,14,15 (mod 256). frame_done pulses once, coincident with it.
- Row wrap: pixels (3,0),(3,1) produce no window. Pixel (3,2) -> row=1, col=0, elements 28,29,30,56,57,58,84,85,86.
- in_valid held high 784 consecutive cycles -> identical 676 windows and values as the paced run; none dropped or duplicated.
- Assert rst for 2 cycles after 300 pixels, including once asynchronously mid-cycle -> all outputs 0 immediately. A following full frame with pattern 255-ramp yields 676 correct windows and none containing ramp data.
- Two frames back-to-back (ramp, then 255-ramp, no idle) -> frame 2's first window is row=0, col=0, elements 255,254,253,227,226,225,199,198,197.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants for the CNN front end, plus the window element index
// helper that downstream conv layers also use to unpack win_data.
package cnn_pkg;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int DATA_W = 8;
    localparam int K      = 3;

    // Flat element index of window position (r,c); element sits at DATA_W*idx.
    function automatic int win_idx(input int r, input int c, input int k = K);
        return k * r + c;
    endfunction
endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage. The read is combinational, so a read and a
// write at the same address in the same cycle return the old contents.
module line_buffer #(
    parameter int DEPTH  = 28,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    // Contents are deliberately not reset; row gating upstream hides stale rows.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/conv_window_gen.sv
// Turns a raster pixel stream into K x K windows for valid (unpadded)
// convolution, tagged with the window's top-left coordinate and end of frame.
module conv_window_gen #(
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int K      = cnn_pkg::K,
    parameter int CW     = $clog2(IMG_W),
    parameter int RW     = $clog2(IMG_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  win_valid,
    output logic [K*K*DATA_W-1:0] win_data,
    output logic [RW-1:0]         win_row,
    output logic [CW-1:0]         win_col,
    output logic                  frame_done
);
    // Stream contract: no ready on either side. Every cycle in_valid is high one
    // pixel is consumed; win_valid is a one-cycle pulse the consumer must take.
    localparam int NLB = K - 1;

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              col_last, row_last, win_ready;
    logic [DATA_W-1:0] win_q   [K][K];
    logic [DATA_W-1:0] new_col [K];
    logic [DATA_W-1:0] lb_rd   [NLB];
    logic [DATA_W-1:0] lb_wd   [NLB];

    logic              emit_q, emit_last_q;
    logic [RW-1:0]     emit_row_q;
    logic [CW-1:0]     emit_col_q;

    logic [K*K*DATA_W-1:0] win_flat;
    logic                  win_valid_q, frame_done_q;
    logic [K*K*DATA_W-1:0] win_data_q;
    logic [RW-1:0]         win_row_q;
    logic [CW-1:0]         win_col_q;

    // lb_rd[0] holds row y-1, lb_rd[NLB-1] holds row y-(K-1).
    for (genvar j = 0; j < NLB; j++) begin : g_lb
        if (j == 0) begin : g_first
            assign lb_wd[j] = in_data;
        end else begin : g_chain
            assign lb_wd[j] = lb_rd[j-1];
        end
        line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_lb (
            .clk     (clk),
            .we_i    (in_valid),
            .addr_i  (col_q),
            .wdata_i (lb_wd[j]),
            .rdata_o (lb_rd[j])
        );
    end

    always_comb begin
        col_last  = (col_q == CW'(IMG_W - 1));
        row_last  = (row_q == RW'(IMG_H - 1));
        win_ready = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
        col_d     = col_q;
        row_d     = row_q;
        if (in_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        for (int r = 0; r < K; r++) begin
            new_col[r] = in_data;
        end
        for (int r = 0; r < K - 1; r++) begin
            new_col[r] = lb_rd[K-2-r];
        end
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[DATA_W*cnn_pkg::win_idx(r, c, K) +: DATA_W] = win_q[r][c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (in_valid) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                    win_q[r][K-1] <= new_col[r];
                end
            end
        end
    end

    // Emit stage: coordinates captured at the accepting edge, published one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            emit_q      <= 1'b0;
            emit_last_q <= 1'b0;
            emit_row_q  <= '0;
            emit_col_q  <= '0;
        end else begin
            emit_q <= in_valid && win_ready;
            if (in_valid && win_ready) begin
                emit_row_q  <= row_q - RW'(K - 1);
                emit_col_q  <= col_q - CW'(K - 1);
                emit_last_q <= col_last && row_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_data_q   <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
        end else begin
            win_valid_q  <= emit_q;
            frame_done_q <= emit_q && emit_last_q;
            if (emit_q) begin
                win_data_q <= win_flat;
                win_row_q  <= emit_row_q;
                win_col_q  <= emit_col_q;
            end
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign win_data   = win_data_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: ramp / inverted-ramp frames, paced and
// continuous input, async reset mid-frame, back-to-back frames.
module tb_conv_window_gen;
  import cnn_pkg::*;

  localparam int PIX = IMG_W * IMG_H;
  localparam int NWIN = (IMG_H - K + 1) * (IMG_W - K + 1);
  localparam int DW = K * K * DATA_W;
  localparam int EW = 1 + 5 + 5 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [DATA_W-1:0] in_data;
  logic win_valid;
  logic [DW-1:0] win_data;
  logic [4:0] win_row;
  logic [4:0] win_col;
  logic frame_done;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_window_gen dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] pix(input int kind, input int y, input int x);
    logic [7:0] v;
    v = 8'((y * IMG_W + x) % 256);
    return (kind != 0) ? (8'd255 - v) : v;
  endfunction

  function automatic logic [DW-1:0] exp_win(input int kind, input int y, input int x);
    logic [DW-1:0] d;
    d = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        d[DATA_W*(K*r+c) +: DATA_W] = pix(kind, y - (K-1) + r, x - (K-1) + c);
    return d;
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int win_cnt, fd_cnt, cap_n, first_cyc, acc58_cyc;
  logic [DW-1:0] first_data, last_data, cap_data, rw_data;
  logic [4:0] first_row, first_col, last_row, last_col;
  logic last_fd;

  always @(negedge clk) begin
    if (!rst) begin
      if (win_valid) begin
        logic [EW-1:0] e;
        win_cnt++;
        if (frame_done) fd_cnt++;
        if (win_cnt == 1) begin
          first_data = win_data; first_row = win_row; first_col = win_col; first_cyc = cyc;
        end
        if (win_cnt == cap_n) cap_data = win_data;
        if (win_row == 5'd1 && win_col == 5'd0) rw_data = win_data;
        last_data = win_data; last_row = win_row; last_col = win_col; last_fd = frame_done;
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_window", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_data", win_data, e[DW-1:0]);
          check_eq("sb_col", win_col, e[DW+4:DW]);
          check_eq("sb_row", win_row, e[DW+9:DW+5]);
          check_eq("sb_frame_done", frame_done, e[EW-1]);
        end
      end else if (frame_done) begin
        check_eq("frame_done_without_window", frame_done, 0);
      end
    end
  end

  // ---------------- driver ----------------
  int by = 0, bx = 0, kind = 0;

  task automatic drive_pixel(input int gap);
    in_valid = 1'b1;
    in_data  = pix(kind, by, bx);
    @(posedge clk); #1;
    if (by == 2 && bx == 2) acc58_cyc = cyc;
    if (by >= K-1 && bx >= K-1)
      exp_q.push_back({(by == IMG_H-1 && bx == IMG_W-1), 5'(by-(K-1)), 5'(bx-(K-1)), exp_win(kind, by, bx)});
    if (bx == IMG_W-1) begin
      bx = 0;
      by = (by == IMG_H-1) ? 0 : by + 1;
    end else begin
      bx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int k_in, input int gap);
    kind = k_in;
    repeat (PIX) drive_pixel(gap);
  endtask

  task automatic reset_stats();
    win_cnt = 0; fd_cnt = 0; cap_n = 0; last_fd = 0;
    first_data = '0; last_data = '0; cap_data = '0; rw_data = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_win_valid"}, win_valid, 0);
    check_eq({tag, "_win_data"}, win_data, 0);
    check_eq({tag, "_win_row"}, win_row, 0);
    check_eq({tag, "_win_col"}, win_col, 0);
    check_eq({tag, "_frame_done"}, frame_done, 0);
  endtask

  localparam logic [DW-1:0] RAMP_FIRST = 72'h3a3938_1e1d1c_020100;
  localparam logic [DW-1:0] RAMP_LAST  = 72'h0f0e0d_f3f2f1_d7d6d5;
  localparam logic [DW-1:0] RAMP_R1C0  = 72'h565554_3a3938_1e1d1c;
  localparam logic [DW-1:0] INV_FIRST  = 72'hc5c6c7_e1e2e3_fdfeff;

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    reset_stats();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Paced ramp frame, one pixel per 51 cycles.
    reset_stats();
    send_frame(0, 50);
    repeat (4) @(negedge clk);
    check_eq("paced_count", win_cnt, NWIN);
    check_eq("paced_frame_done_count", fd_cnt, 1);
    check_eq("paced_first_latency", first_cyc - acc58_cyc, 1);
    check_eq("paced_first_row", first_row, 0);
    check_eq("paced_first_col", first_col, 0);
    check_eq("paced_first_data", first_data, RAMP_FIRST);
    check_eq("paced_last_row", last_row, 25);
    check_eq("paced_last_col", last_col, 25);
    check_eq("paced_last_data", last_data, RAMP_LAST);
    check_eq("paced_last_frame_done", last_fd, 1);
    check_eq("paced_row_wrap_data", rw_data, RAMP_R1C0);
    check_eq("paced_queue_drained", exp_q.size(), 0);

    // Same ramp with in_valid held high for the whole frame.
    reset_stats();
    send_frame(0, 0);
    repeat (4) @(negedge clk);
    check_eq("burst_count", win_cnt, NWIN);
    check_eq("burst_frame_done_count", fd_cnt, 1);
    check_eq("burst_first_data", first_data, RAMP_FIRST);
    check_eq("burst_last_data", last_data, RAMP_LAST);
    check_eq("burst_queue_drained", exp_q.size(), 0);

    // 300 ramp pixels, then asynchronous reset mid-cycle.
    reset_stats();
    kind = 0;
    repeat (300) drive_pixel(0);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_reset");
    exp_q.delete();
    by = 0; bx = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_stats();
    send_frame(1, 0);
    repeat (4) @(negedge clk);
    check_eq("post_reset_count", win_cnt, NWIN);
    check_eq("post_reset_frame_done_count", fd_cnt, 1);
    check_eq("post_reset_first_data", first_data, INV_FIRST);
    check_eq("post_reset_queue_drained", exp_q.size(), 0);

    // Back-to-back frames with no idle gap.
    reset_stats();
    cap_n = NWIN + 1;
    send_frame(0, 0);
    send_frame(1, 0);
    repeat (4) @(negedge clk);
    check_eq("b2b_count", win_cnt, 2 * NWIN);
    check_eq("b2b_frame_done_count", fd_cnt, 2);
    check_eq("b2b_frame2_first_data", cap_data, INV_FIRST);
    check_eq("b2b_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
